// File: rtl/breakout_pkg.sv
// breakout_pkg: shared breakout types, direction encodings and default screen bounds
package breakout_pkg;
  typedef enum logic [1:0] {SERVE, PLAY, RESOLVE, MOVE} state_t;
  typedef struct packed {
    logic t;
    logic b;
    logic l;
    logic r;
  } contact_t;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT = 1'b1;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int SCREEN_X_MIN = 8;
  localparam int SCREEN_X_MAX = 627;
  localparam int SCREEN_Y_MIN = 8;
  localparam int SCREEN_Y_LOST = 475;
  localparam int BALL_START_X = 320;
  localparam int BALL_START_Y = 400;
endpackage

// File: rtl/ball_mover_if.sv
// ball_mover_if: painter/playfield inputs and ball state outputs of the ball mover
//   master: drives collision regions, obstacle, display_active, frame_pulse, serve
//   slave:  the mover; returns x, y, dir_x, dir_y, hit, lost, playing
interface ball_mover_if;
  logic in_ball_top, in_ball_bottom, in_ball_left, in_ball_right;
  logic obstacle, display_active, frame_pulse, serve;
  logic [9:0] x;
  logic [8:0] y;
  logic dir_x, dir_y, hit, lost, playing;
  modport master (
    output in_ball_top, in_ball_bottom, in_ball_left, in_ball_right,
    output obstacle, display_active, frame_pulse, serve,
    input x, y, dir_x, dir_y, hit, lost, playing
  );
  modport slave (
    input in_ball_top, in_ball_bottom, in_ball_left, in_ball_right,
    input obstacle, display_active, frame_pulse, serve,
    output x, y, dir_x, dir_y, hit, lost, playing
  );
endinterface

// File: rtl/ball_mover_collision_latch.sv
// collision_latch: four sticky contact flags {t,b,l,r} sampled against solid visible pixels
//   clk, nRst: clock, async active-low reset
//   display_active, obstacle: qualify a region as a real contact
//   sample: capture enable; clr: synchronous clear (wins over sample)
//   region: current pixel's ball regions; flags: latched contacts
module collision_latch (
  input  logic       clk,
  input  logic       nRst,
  input  logic       display_active,
  input  logic       obstacle,
  input  logic       sample,
  input  logic       clr,
  input  logic [3:0] region,
  output logic [3:0] flags
);
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) flags <= '0;
    else if (clr) flags <= '0;
    else if (sample) flags <= flags | (region & {4{display_active & obstacle}});
endmodule

// File: rtl/ball_mover.sv
// ball_mover: latches ball contacts during a frame, reflects and advances the ball once per frame
//   clk, nRst: pixel clock, async active-low reset
//   bus (slave): painter regions, obstacle, display_active, frame_pulse, serve in;
//                x, y, dir_x, dir_y, hit, lost, playing out (all registered)
module ball_mover
  import breakout_pkg::*;
#(
  parameter int START_X = BALL_START_X,
  parameter int START_Y = BALL_START_Y,
  parameter int SPEED   = 1,
  parameter int X_MIN   = SCREEN_X_MIN,
  parameter int X_MAX   = SCREEN_X_MAX,
  parameter int Y_MIN   = SCREEN_Y_MIN,
  parameter int Y_LOST  = SCREEN_Y_LOST
) (
  input logic clk,
  input logic nRst,
  ball_mover_if.slave bus
);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [9:0] SX = 10'(START_X);
  localparam logic [8:0] SY = 9'(START_Y);
  state_t state, state_n;
  contact_t flags, region;
  logic [9:0] x_n;
  logic [8:0] y_n;
  logic dx_n, dy_n, hit_n, lost_n;
  logic [10:0] xw, xl, xr, yw, yu, yd;
  logic x_lo, x_hi, y_lo, y_out;
  assign region = {bus.in_ball_top, bus.in_ball_bottom, bus.in_ball_left, bus.in_ball_right};
  collision_latch u_latch (
    .clk(clk),
    .nRst(nRst),
    .display_active(bus.display_active),
    .obstacle(bus.obstacle),
    .sample(state == PLAY),
    .clr(state == MOVE),
    .region(region),
    .flags(flags)
  );
  // 11-bit arithmetic; the explicit borrow term keeps x-SPEED from wrapping past zero
  assign xw = {1'b0, bus.x};
  assign xl = xw - SP;
  assign xr = xw + SP;
  assign x_lo = (xw < SP) || (xl < 11'(X_MIN));
  assign x_hi = xr > 11'(X_MAX);
  assign yw = {2'b00, bus.y};
  assign yu = yw - SP;
  assign yd = yw + SP;
  assign y_lo = (yw < SP) || (yu < 11'(Y_MIN));
  assign y_out = yd >= 11'(Y_LOST);
  always_comb begin
    state_n = state;
    x_n = bus.x;
    y_n = bus.y;
    dx_n = bus.dir_x;
    dy_n = bus.dir_y;
    hit_n = 1'b0;
    lost_n = 1'b0;
    unique case (state)
      SERVE: begin
        x_n = SX;
        y_n = SY;
        if (bus.serve) begin
          state_n = PLAY;
          dx_n = DIR_RIGHT;
          dy_n = DIR_UP;
        end
      end
      PLAY: state_n = bus.frame_pulse ? RESOLVE : PLAY;
      RESOLVE: begin
        // only a contact on the side the ball is heading toward reflects it
        dy_n = (flags.t && bus.dir_y == DIR_UP) ? DIR_DOWN :
               (flags.b && bus.dir_y == DIR_DOWN) ? DIR_UP : bus.dir_y;
        dx_n = (flags.l && bus.dir_x == DIR_LEFT) ? DIR_RIGHT :
               (flags.r && bus.dir_x == DIR_RIGHT) ? DIR_LEFT : bus.dir_x;
        hit_n = (dx_n != bus.dir_x) || (dy_n != bus.dir_y);
        state_n = MOVE;
      end
      MOVE: begin
        x_n = bus.dir_x == DIR_LEFT ? (x_lo ? 10'(X_MIN) : xl[9:0]) : (x_hi ? 10'(X_MAX) : xr[9:0]);
        dx_n = bus.dir_x == DIR_LEFT ? (x_lo ? DIR_RIGHT : DIR_LEFT) : (x_hi ? DIR_LEFT : DIR_RIGHT);
        state_n = PLAY;
        if (bus.dir_y == DIR_UP) begin
          y_n = y_lo ? 9'(Y_MIN) : yu[8:0];
          dy_n = y_lo ? DIR_DOWN : DIR_UP;
        end else if (y_out) begin
          lost_n = 1'b1;
          x_n = SX;
          y_n = SY;
          dx_n = DIR_RIGHT;
          dy_n = DIR_UP;
          state_n = SERVE;
        end else begin
          y_n = yd[8:0];
        end
      end
      default: state_n = SERVE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state <= SERVE;
      bus.x <= SX;
      bus.y <= SY;
      bus.dir_x <= DIR_RIGHT;
      bus.dir_y <= DIR_UP;
      bus.hit <= 1'b0;
      bus.lost <= 1'b0;
      bus.playing <= 1'b0;
    end else begin
      state <= state_n;
      bus.x <= x_n;
      bus.y <= y_n;
      bus.dir_x <= dx_n;
      bus.dir_y <= dy_n;
      bus.hit <= hit_n;
      bus.lost <= lost_n;
      bus.playing <= state_n != SERVE;
    end
endmodule

// File: tb/tb_ball_mover.sv
// tb_ball_mover: directed vector table plus cycle-exact sequences for ball_mover
module tb_ball_mover;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic [3:0] con = '0;
  logic obs = 1'b0, disp = 1'b0, fp = 1'b0, srv = 1'b0;
  int nchk = 0, nfail = 0, hits0 = 0, hits1 = 0, lost2 = 0;
  always #5 clk = ~clk;
  ball_mover_if b0 ();
  ball_mover_if b1 ();
  ball_mover_if b2 ();
  assign {b0.in_ball_top, b0.in_ball_bottom, b0.in_ball_left, b0.in_ball_right} = con;
  assign {b1.in_ball_top, b1.in_ball_bottom, b1.in_ball_left, b1.in_ball_right} = con;
  assign {b2.in_ball_top, b2.in_ball_bottom, b2.in_ball_left, b2.in_ball_right} = con;
  assign {b0.obstacle, b0.display_active, b0.frame_pulse, b0.serve} = {obs, disp, fp, srv};
  assign {b1.obstacle, b1.display_active, b1.frame_pulse, b1.serve} = {obs, disp, fp, srv};
  assign {b2.obstacle, b2.display_active, b2.frame_pulse, b2.serve} = {obs, disp, fp, srv};
  ball_mover u0 (.clk(clk), .nRst(nRst), .bus(b0));
  ball_mover #(.START_X(9), .SPEED(2)) u1 (.clk(clk), .nRst(nRst), .bus(b1));
  ball_mover #(.START_Y(470)) u2 (.clk(clk), .nRst(nRst), .bus(b2));
  typedef struct {
    logic srv;
    logic [3:0] c0;
    logic d0, o0;
    logic [3:0] c1;
    logic d1, o1;
    int frames, ex, ey, edx, edy, ehit, eplay;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    hits0 += int'(b0.hit);
    hits1 += int'(b1.hit);
    lost2 += int'(b2.lost);
  endtask
  task automatic do_reset();
    {con, obs, disp, fp, srv} = '0;
    nRst = 1'b0;
    tick();
    nRst = 1'b1;
    tick();
    hits0 = 0;
    hits1 = 0;
    lost2 = 0;
  endtask
  task automatic do_serve();
    srv = 1'b1;
    tick();
    srv = 1'b0;
  endtask
  task automatic frame(input logic [3:0] c0, input logic d0, o0, input logic [3:0] c1, input logic d1, o1);
    {con, disp, obs} = {c0, d0, o0};
    tick();
    {con, disp, obs} = {c1, d1, o1};
    tick();
    {con, disp, obs} = '0;
    fp = 1'b1;
    tick();
    fp = 1'b0;
    tick();
    tick();
    tick();
  endtask
  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) frame(4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask
  initial begin
    // srv, c0(TBLR) d0 o0, c1 d1 o1, frames, x, y, dir_x, dir_y, hits, playing
    vt[0]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3, 320, 400, 0, 1, 0, 0};
    vt[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3, 323, 397, 0, 1, 0, 1};
    vt[2]  = '{1'b1, 4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 321, 401, 0, 0, 1, 1};
    vt[3]  = '{1'b1, 4'h4, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 321, 399, 0, 1, 0, 1};
    vt[4]  = '{1'b1, 4'h8, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1, 321, 399, 0, 1, 0, 1};
    vt[5]  = '{1'b1, 4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1, 321, 399, 0, 1, 0, 1};
    vt[6]  = '{1'b1, 4'h4, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1, 321, 399, 0, 1, 0, 1};
    vt[7]  = '{1'b1, 4'hC, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 321, 401, 0, 0, 1, 1};
    vt[8]  = '{1'b1, 4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 319, 399, 1, 1, 1, 1};
    vt[9]  = '{1'b1, 4'h2, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 321, 399, 0, 1, 0, 1};
    vt[10] = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 319, 399, 1, 1, 1, 1};
    vt[11] = '{1'b1, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1, 319, 401, 1, 0, 1, 1};
    vt[12] = '{1'b1, 4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 2, 322, 402, 0, 0, 1, 1};
    for (int v = 0; v < 13; v++) begin
      do_reset();
      if (vt[v].srv) do_serve();
      frame(vt[v].c0, vt[v].d0, vt[v].o0, vt[v].c1, vt[v].d1, vt[v].o1);
      quiet(vt[v].frames - 1);
      chk($sformatf("v%0d x", v), int'(b0.x), vt[v].ex);
      chk($sformatf("v%0d y", v), int'(b0.y), vt[v].ey);
      chk($sformatf("v%0d dir_x", v), int'(b0.dir_x), vt[v].edx);
      chk($sformatf("v%0d dir_y", v), int'(b0.dir_y), vt[v].edy);
      chk($sformatf("v%0d hits", v), hits0, vt[v].ehit);
      chk($sformatf("v%0d playing", v), int'(b0.playing), vt[v].eplay);
    end
    do_reset();
    chk("rst x", int'(b0.x), 320);
    chk("rst y", int'(b0.y), 400);
    chk("rst dirs", int'({b0.dir_x, b0.dir_y}), 1);
    chk("rst pulses", int'({b0.hit, b0.lost, b0.playing}), 0);
    do_serve();
    chk("serve playing", int'(b0.playing), 1);
    {con, disp, obs} = {4'h8, 1'b1, 1'b1};
    tick();
    {con, disp, obs} = '0;
    fp = 1'b1;
    tick();
    fp = 1'b0;
    chk("N+1 hit", int'(b0.hit), 0);
    tick();
    chk("N+2 hit", int'(b0.hit), 1);
    chk("N+2 y", int'(b0.y), 400);
    tick();
    chk("N+3 hit", int'(b0.hit), 0);
    chk("N+3 dir_y", int'(b0.dir_y), 0);
    chk("N+3 y", int'(b0.y), 401);
    chk("N+3 x", int'(b0.x), 321);
    do_reset();
    do_serve();
    {con, disp, obs, fp} = {4'h8, 1'b1, 1'b1, 1'b1};
    tick();
    {con, disp, obs} = '0;
    tick();
    tick();
    fp = 1'b0;
    tick();
    tick();
    tick();
    chk("same-cycle dir_y", int'(b0.dir_y), 0);
    chk("same-cycle y", int'(b0.y), 401);
    chk("same-cycle hits", hits0, 1);
    do_reset();
    chk("clamp rst x", int'(b1.x), 9);
    do_serve();
    frame(4'h1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("clamp x", int'(b1.x), 8);
    chk("clamp dir_x", int'(b1.dir_x), 0);
    chk("clamp hits", hits1, 1);
    chk("clamp y", int'(b1.y), 398);
    do_reset();
    do_serve();
    frame(4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    chk("loss f1 y", int'(b2.y), 471);
    quiet(3);
    chk("loss f4 y", int'(b2.y), 474);
    chk("loss f4 lost", lost2, 0);
    quiet(1);
    chk("loss lost", lost2, 1);
    chk("loss x", int'(b2.x), 320);
    chk("loss y", int'(b2.y), 470);
    chk("loss playing", int'(b2.playing), 0);
    chk("loss dirs", int'({b2.dir_x, b2.dir_y}), 1);
    quiet(1);
    chk("serve idle y", int'(b2.y), 470);
    do_reset();
    do_serve();
    frame(4'h8, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    quiet(3);
    chk("pre-move y", int'(b2.y), 474);
    fp = 1'b1;
    tick();
    fp = 1'b0;
    tick();
    nRst = 1'b0;
    #1;
    chk("async y", int'(b2.y), 470);
    chk("async x", int'(b2.x), 320);
    chk("async playing", int'(b2.playing), 0);
    chk("async dirs", int'({b2.dir_x, b2.dir_y}), 1);
    tick();
    nRst = 1'b1;
    lost2 = 0;
    tick();
    tick();
    tick();
    chk("no lost after rst", lost2, 0);
    chk("idle after rst", int'(b2.playing), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/ball_mover.md
# ball_mover

Ball motion and collision-response engine for the breakout game. It samples the ball painter's four edge-region flags against the playfield "solid pixel" signal during active display and latches any contacts. Once per frame it reflects the ball direction and advances the ball position. It drives the painter's `x`/`y` inputs, so it closes the loop from painter collision outputs back to ball position.

## Interface
Parameters:
- `START_X`, default 320: serve x (ball top-left).
- `START_Y`, default 400: serve y.
- `SPEED`, default 1: pixels moved per frame per axis; legal range 1..3.
- `X_MIN`, default 8: leftmost legal x.
- `X_MAX`, default 627: rightmost legal x.
- `Y_MIN`, default 8: topmost legal y.
- `Y_LOST`, default 475: a y at or beyond this value means the ball is lost.

Ports:
- `clk`, in, 1: pixel clock.
- `nRst`, in, 1: asynchronous, active-low reset.
- `in_ball_top`, `in_ball_bottom`, `in_ball_left`, `in_ball_right`, in, 1 each: painter collision regions for the current pixel.
- `obstacle`, in, 1: current pixel is solid (brick, wall or paddle).
- `display_active`, in, 1: current pixel is visible.
- `frame_pulse`, in, 1: one-cycle strobe, once per frame, outside active display.
- `serve`, in, 1: launch request.
- `x`, out, 10: ball x.
- `y`, out, 9: ball y.
- `dir_x`, out, 1: 0 = right, 1 = left.
- `dir_y`, out, 1: 1 = up, 0 = down.
- `hit`, out, 1: one-cycle pulse when any reflection occurs.
- `lost`, out, 1: one-cycle pulse when the ball is lost.
- `playing`, out, 1: high in PLAY, RESOLVE and MOVE.

## Operation
- Reset values: state SERVE, `x`=START_X, `y`=START_Y, `dir_x`=0, `dir_y`=1, `hit`=0, `lost`=0, `playing`=0, all flags clear.
- SERVE:
  - `x`/`y` are held at START.
  - `frame_pulse` is ignored.
  - `serve`=1 moves to PLAY with `dir_x`=0 and `dir_y`=1.
- PLAY:
  - Each cycle, flag_T is set if `display_active & obstacle & in_ball_top`. flag_B, flag_L and flag_R are set the same way from their regions.
  - Flags are sticky until cleared.
  - `serve` is ignored.
  - `frame_pulse` moves to RESOLVE. A flag condition in the same cycle as `frame_pulse` is still captured.
- RESOLVE, one cycle, reflection only toward the contact:
  - flag_T with `dir_y`=1 sets `dir_y`=0.
  - flag_B with `dir_y`=0 sets `dir_y`=1.
  - flag_L with `dir_x`=1 sets `dir_x`=0.
  - flag_R with `dir_x`=0 sets `dir_x`=1.
  - Opposing flags on one axis (T and B, or L and R) reflect at most once, using the current direction.
  - `hit` is registered high for one cycle if any direction changed.
  - Next state is MOVE.
- MOVE, one cycle, uses the post-RESOLVE directions:
  - x: moving left with x−SPEED < X_MIN gives x=X_MIN and `dir_x`=0. Moving right with x+SPEED > X_MAX gives x=X_MAX and `dir_x`=1. Otherwise x ± SPEED.
  - y: moving up with y−SPEED < Y_MIN gives y=Y_MIN and `dir_y`=0.
  - Wall clamps do not assert `hit`.
  - Moving down with y+SPEED ≥ Y_LOST: `lost` pulses, `x`/`y` return to START, `dir_x`=0, `dir_y`=1, next state SERVE.
  - Otherwise y ± SPEED, flags cleared, next state PLAY.
- Arithmetic:
  - Compare in 11-bit unsigned with an explicit borrow check, so no underflow wraps.
  - `x` is 10 bits, `y` is 9 bits.
- Asynchronous reset at any point, including mid-RESOLVE or mid-MOVE, returns everything to reset values immediately.

## Timing
- `frame_pulse` is high in cycle N.
- Cycle N+1: RESOLVE.
- Cycle N+2: MOVE, and `hit` is high if there was a reflection.
- Cycle N+3: new `x`/`y`/`dir_*` visible, `lost` high if applicable.
- Cycle N+3: flags are clear and sampling resumes.
- `serve` in cycle S: `playing`=1 from S+1.
- All outputs are registered.
- A `frame_pulse` arriving during RESOLVE or MOVE is ignored. The protocol guarantees frames are longer than 3 cycles.

## Structure
- Shared package `breakout_pkg` holds:
  - the state encoding (SERVE, PLAY, RESOLVE, MOVE);
  - the direction constants DIR_RIGHT/DIR_LEFT and DIR_UP/DIR_DOWN;
  - the default screen bounds, shared with the painter and the playfield.
- One sub-module, `collision_latch`: the four sticky flags, with qualify inputs (`display_active`, `obstacle`), a sample enable and a synchronous clear.

## Test plan
- Reset and idle: after reset, `x`=320, `y`=400, `playing`=0. Three `frame_pulse`s with no `serve` leave the position unchanged.
- Free flight: `serve`, then 3 frames with no obstacle. Result `x`=323, `y`=397, `dir_x`=0, `dir_y`=1, `hit` never high.
- Top hit: `serve`, then one active cycle with `in_ball_top`, `obstacle` and `display_active` high, then `frame_pulse` at N. Required: `hit`=1 at N+2; at N+3 `dir_y`=0, `y`=401, `x`=321.
- Non-reflection and qualification:
  - `in_ball_bottom` with `obstacle` while moving up gives no direction change and `hit`=0.
  - `in_ball_top` with `obstacle` while `display_active`=0 gives no change.
  - Set both in the same frame: a single frame must show both responses (no direction change, no `hit`).
- Left clamp: START_X=9, SPEED=2; `serve`, right-region hit in frame 1. Required: frame 1 gives `dir_x`=1, `x`=7 clamped to 8, `dir_x`=0, `hit`=1 once.
- Loss and reset mid-op:
  - START_Y=470, SPEED=1; top hit in frame 1 gives `y`=471.
  - Frames 2–4 give `y`=474. Frame 5 gives `lost`=1, `x`=START_X, `y`=470, state SERVE.
  - Assert `nRst` low during MOVE: outputs return to reset values and no `lost` pulse follows.
